// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and prescale width.
// Imported by both the TX engine and the RX sampling path.
package uart_pkg;

    localparam int   PRESCALE_W = 6;
    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter: counts 0..prescale-1 while enabled and flags the last clock of each bit.
// Same structure as the RX edge counter so both sides agree on bit boundaries.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_tick
);

    logic [PRESCALE_W-1:0] count_q;

    assign bit_tick = en && (count_q == prescale - PRESCALE_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (!en || bit_tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: serialises a latched byte LSB-first as start, data, optional parity, stop.
// Each bit is held for prescale clocks; TX_OUT and busy are driven straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q, state_d;
    logic [BIT_W-1:0]      bit_q, bit_d, bit_inc;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  bit_tick;
    logic [DATA_WIDTH-1:0] data_l;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic [PRESCALE_W-1:0] prescale_l;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (typ == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign accept  = (state_q == ST_IDLE) && DATA_VALID && (prescale != '0);
    assign bit_inc = bit_q + BIT_W'(1);
    assign TX_OUT  = tx_q;
    assign busy    = busy_q;

    uart_tx_bit_timer u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != ST_IDLE),
        .prescale (prescale_l),
        .bit_tick (bit_tick)
    );

    // Next-state and next-output: the output flop is loaded with the level of the bit being entered
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = data_l[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_l ? ST_PARITY : ST_STOP;
                        tx_d    = par_en_l ? parity_bit(data_l, par_typ_l) : 1'b1;
                    end else begin
                        bit_d = bit_inc;
                        tx_d  = data_l[bit_inc];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            prescale_l <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (accept) begin
                prescale_l <= prescale;
            end
        end
    end

    // Payload fields are only consumed after an accept, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            data_l    <= P_DATA;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
        end
    end

endmodule
